// File: rtl/rs_csr_multi.sv
// Reservation station for CSR-class ops: DEPTH entries with one renamed source
// tag each, NUM_WB writeback wakeup channels, oldest-ready select through an
// age matrix, and a valid/ready issue register in front of the CSR unit.
module rs_csr_multi #(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 8,
  parameter int INUM_W = 32,
  parameter int DATA_W = 32,
  parameter int NUM_WB = 6
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      flush,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [INUM_W-1:0]                         in_inst_num,
  input  logic [TAG_W-1:0]                          in_rd,
  input  logic [3:0]                                in_aluop,
  input  logic                                      in_alusrc2,
  input  logic [11:0]                               in_csr_addr,
  input  logic [DATA_W-1:0]                         in_csr_data,
  input  logic [DATA_W-1:0]                         in_imm,
  input  logic [TAG_W-1:0]                          in_src_tag,
  input  logic                                      in_src_rdy,
  input  logic [NUM_WB-1:0]                         wb_valid,
  input  logic [NUM_WB*TAG_W-1:0]                   wb_tag,
  output logic                                      issue_valid,
  input  logic                                      issue_ready,
  output logic [INUM_W+2*TAG_W+4+1+12+2*DATA_W-1:0] issue_bus,
  output logic [$clog2(DEPTH):0]                    count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam int BUS_W = INUM_W + 2*TAG_W + 4 + 1 + 12 + 2*DATA_W;

  // True when any valid broadcast channel carries the given tag.
  function automatic logic wb_match(input logic [TAG_W-1:0]        tag,
                                    input logic [NUM_WB-1:0]       v,
                                    input logic [NUM_WB*TAG_W-1:0] t);
    logic hit;
    hit = 1'b0;
    for (int c = 0; c < NUM_WB; c++)
      if (v[c] && (t[c*TAG_W +: TAG_W] == tag)) hit = 1'b1;
    return hit;
  endfunction

  logic [DEPTH-1:0] entry_vld;
  logic [DEPTH-1:0] entry_rdy;
  logic [DEPTH-1:0] older [DEPTH];   // older[i][j]: j was allocated before i
  logic [BUS_W-1:0] payload [DEPTH];
  logic [CNT_W-1:0] count_q;

  logic [BUS_W-1:0] in_bus;
  logic             in_hit;
  logic [DEPTH-1:0] wake_hit;
  logic [DEPTH-1:0] ready_vec;
  logic [DEPTH-1:0] has_older;
  logic [IDX_W-1:0] alloc_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;
  logic             accept;
  logic             load;

  logic             vld_p1;
  logic [BUS_W-1:0] bus_p1;

  // Source tag sits on top so the wakeup compare can slice it from the payload.
  assign in_bus   = {in_src_tag, in_inst_num, in_rd, in_aluop, in_alusrc2,
                     in_csr_data, in_csr_addr, in_imm};
  assign in_hit   = wb_match(in_src_tag, wb_valid, wb_tag);
  assign in_ready = (count_q < CNT_W'(DEPTH));
  assign accept   = in_valid & in_ready & ~flush;
  assign load     = sel_found & (~vld_p1 | issue_ready) & ~flush;

  // Per-entry wakeup match and age-qualified readiness.
  always_comb begin
    wake_hit  = '0;
    ready_vec = entry_vld & entry_rdy;
    has_older = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wake_hit[i]  = wb_match(payload[i][BUS_W-1 -: TAG_W], wb_valid, wb_tag);
      has_older[i] = |(ready_vec & older[i]);
    end
  end

  // Allocation target: lowest-index free entry.
  always_comb begin
    alloc_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (!entry_vld[i]) alloc_idx = IDX_W'(i);
  end

  // Select: the one ready entry with no older ready entry.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ready_vec[i] && !has_older[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
  end

  // Entry occupancy, readiness and age matrix.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry_vld <= '0;
      entry_rdy <= '0;
      for (int k = 0; k < DEPTH; k++) older[k] <= '0;
    end else if (flush) begin
      entry_vld <= '0;
      entry_rdy <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (entry_vld[i] && !entry_rdy[i] && wake_hit[i]) entry_rdy[i] <= 1'b1;
      if (load) entry_vld[sel_idx] <= 1'b0;
      if (accept) begin
        entry_vld[alloc_idx] <= 1'b1;
        entry_rdy[alloc_idx] <= in_src_rdy | in_hit;
        // New entry is younger than everything; drop stale bits naming this slot.
        for (int k = 0; k < DEPTH; k++) older[k][alloc_idx] <= 1'b0;
        older[alloc_idx] <= entry_vld;
      end
    end
  end

  // Payload storage; only meaningful while the entry is occupied.
  always_ff @(posedge clk) begin
    if (accept) payload[alloc_idx] <= in_bus;
  end

  // Occupancy counter, excluding the issue register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      count_q <= '0;
    else if (flush) count_q <= '0;
    else            count_q <= count_q + CNT_W'(accept) - CNT_W'(load);
  end

  // ---- stage p1: issue register (holds while stalled) ----
  // Load a selected entry when empty or draining, otherwise drop on handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      bus_p1 <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (load) begin
      vld_p1 <= 1'b1;
      bus_p1 <= payload[sel_idx];
    end else if (issue_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign issue_valid = vld_p1;
  assign issue_bus   = bus_p1;
  assign count       = count_q;

endmodule

// File: tb/tb_rs_csr_multi.sv
// Directed bench for rs_csr_multi: dispatch, wakeup, bypass, full, stall,
// flush and asynchronous reset, each with hand-computed expectations.
module tb_rs_csr_multi;

  localparam int DEPTH  = 16;
  localparam int TAG_W  = 8;
  localparam int INUM_W = 32;
  localparam int DATA_W = 32;
  localparam int NUM_WB = 6;
  localparam int BUS_W  = INUM_W + 2*TAG_W + 4 + 1 + 12 + 2*DATA_W;
  localparam int INUM_LSB = BUS_W - TAG_W - INUM_W;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic [INUM_W-1:0]        in_inst_num;
  logic [TAG_W-1:0]         in_rd;
  logic [3:0]               in_aluop;
  logic                     in_alusrc2;
  logic [11:0]              in_csr_addr;
  logic [DATA_W-1:0]        in_csr_data;
  logic [DATA_W-1:0]        in_imm;
  logic [TAG_W-1:0]         in_src_tag;
  logic                     in_src_rdy;
  logic [NUM_WB-1:0]        wb_valid;
  logic [NUM_WB*TAG_W-1:0]  wb_tag;
  logic                     issue_valid;
  logic                     issue_ready;
  logic [BUS_W-1:0]         issue_bus;
  logic [$clog2(DEPTH):0]   count;

  int n_pass  = 0;
  int n_total = 0;

  rs_csr_multi #(.DEPTH(DEPTH), .TAG_W(TAG_W), .INUM_W(INUM_W),
                 .DATA_W(DATA_W), .NUM_WB(NUM_WB)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst_num(in_inst_num), .in_rd(in_rd), .in_aluop(in_aluop),
    .in_alusrc2(in_alusrc2), .in_csr_addr(in_csr_addr),
    .in_csr_data(in_csr_data), .in_imm(in_imm),
    .in_src_tag(in_src_tag), .in_src_rdy(in_src_rdy),
    .wb_valid(wb_valid), .wb_tag(wb_tag),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_bus(issue_bus), .count(count)
  );

  always #5 clk = ~clk;

  // Reference packing of an op's fields, all derived from tag and inst_num.
  function automatic logic [BUS_W-1:0] mk_bus(input logic [TAG_W-1:0] tag,
                                              input logic [INUM_W-1:0] inum);
    logic [TAG_W-1:0]  rd;
    logic [DATA_W-1:0] cdat;
    logic [11:0]       caddr;
    rd    = inum[7:0] ^ 8'h5A;
    cdat  = inum * 3;
    caddr = 12'h300 + {8'h00, inum[3:0]};
    return {tag, inum, rd, inum[3:0], inum[0], cdat, caddr, ~inum};
  endfunction

  task automatic check(input string tag, input logic [BUS_W-1:0] obs,
                       input logic [BUS_W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [INUM_W-1:0] inum, input logic [TAG_W-1:0] tag,
                       input logic rdy);
    logic [BUS_W-1:0] b;
    b = mk_bus(tag, inum);
    in_valid    = 1'b1;
    in_inst_num = inum;
    in_src_tag  = tag;
    in_src_rdy  = rdy;
    in_rd       = b[INUM_LSB-1 -: TAG_W];
    in_aluop    = inum[3:0];
    in_alusrc2  = inum[0];
    in_csr_data = inum * 3;
    in_csr_addr = 12'h300 + {8'h00, inum[3:0]};
    in_imm      = ~inum;
  endtask

  function automatic logic [INUM_W-1:0] inst_of(input logic [BUS_W-1:0] b);
    return b[INUM_LSB +: INUM_W];
  endfunction

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; issue_ready = 1'b1;
    in_inst_num = '0; in_rd = '0; in_aluop = '0; in_alusrc2 = 1'b0;
    in_csr_addr = '0; in_csr_data = '0; in_imm = '0; in_src_tag = '0;
    in_src_rdy = 1'b0; wb_valid = '0; wb_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_issue_valid", BUS_W'(issue_valid), BUS_W'(0));
    check("rst_issue_bus",   issue_bus,           BUS_W'(0));
    check("rst_count",       BUS_W'(count),       BUS_W'(0));
    check("rst_in_ready",    BUS_W'(in_ready),    BUS_W'(1));
    reset = 1'b0;

    // 1: ready op issues one cycle after accept
    drive(5, 8'h11, 1'b1);
    tick(); in_valid = 1'b0;
    check("t1_count_acc",  BUS_W'(count),       BUS_W'(1));
    check("t1_valid_acc",  BUS_W'(issue_valid), BUS_W'(0));
    tick();
    check("t1_valid",      BUS_W'(issue_valid), BUS_W'(1));
    check("t1_bus",        issue_bus,           mk_bus(8'h11, 5));
    check("t1_count",      BUS_W'(count),       BUS_W'(0));
    tick();
    check("t1_drained",    BUS_W'(issue_valid), BUS_W'(0));

    // 2: three waiting ops woken by DIV channel, issue in age order
    for (int k = 1; k <= 3; k++) begin
      drive(k, 8'h20, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    check("t2_count_wait", BUS_W'(count),       BUS_W'(3));
    check("t2_not_issued", BUS_W'(issue_valid), BUS_W'(0));
    wb_valid = 6'b000100;
    wb_tag = '0;
    wb_tag[2*TAG_W +: TAG_W] = 8'h20;
    wb_tag[0 +: TAG_W]       = 8'h21;
    tick(); wb_valid = '0;
    check("t2_wake_edge",  BUS_W'(issue_valid), BUS_W'(0));
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("t2_issue_valid", BUS_W'(issue_valid), BUS_W'(1));
      check("t2_issue_bus",   issue_bus,           mk_bus(8'h20, k));
      check("t2_count",       BUS_W'(count),       BUS_W'(3 - k));
    end
    tick();
    check("t2_drained",    BUS_W'(issue_valid), BUS_W'(0));

    // 3: same-cycle bypass wakeup at allocation
    drive(7, 8'h33, 1'b0);
    wb_valid = 6'b000001;
    wb_tag = '0;
    wb_tag[0 +: TAG_W] = 8'h33;
    tick(); in_valid = 1'b0; wb_valid = '0;
    check("t3_count",      BUS_W'(count),       BUS_W'(1));
    tick();
    check("t3_issue",      BUS_W'(issue_valid), BUS_W'(1));
    check("t3_bus",        BUS_W'(inst_of(issue_bus)), BUS_W'(7));
    tick();
    check("t3_count_end",  BUS_W'(count),       BUS_W'(0));

    // 4: fill, reject 17th, wake one
    for (int k = 0; k < DEPTH; k++) begin
      drive(100 + k, 8'(8'h40 + k), 1'b0);
      tick();
    end
    check("t4_full_count", BUS_W'(count),    BUS_W'(16));
    check("t4_full_ready", BUS_W'(in_ready), BUS_W'(0));
    drive(999, 8'h41, 1'b1);
    tick(); in_valid = 1'b0;
    check("t4_17th_count", BUS_W'(count),       BUS_W'(16));
    check("t4_17th_issue", BUS_W'(issue_valid), BUS_W'(0));
    wb_valid = 6'b010000;
    wb_tag = '0;
    wb_tag[4*TAG_W +: TAG_W] = 8'h45;
    tick(); wb_valid = '0;
    check("t4_wake_ready", BUS_W'(in_ready), BUS_W'(0));
    tick();
    check("t4_ready_back", BUS_W'(in_ready),    BUS_W'(1));
    check("t4_count15",    BUS_W'(count),       BUS_W'(15));
    check("t4_issue_inst", BUS_W'(inst_of(issue_bus)), BUS_W'(105));
    flush = 1'b1;
    tick(); flush = 1'b0;
    check("t4_flush_cnt",  BUS_W'(count),       BUS_W'(0));
    check("t4_flush_vld",  BUS_W'(issue_valid), BUS_W'(0));

    // 5: stall holds the issue register
    issue_ready = 1'b0;
    drive(50, 8'h51, 1'b1);
    tick();
    drive(51, 8'h52, 1'b1);
    tick(); in_valid = 1'b0;
    check("t5_load_vld",   BUS_W'(issue_valid), BUS_W'(1));
    check("t5_load_bus",   issue_bus,           mk_bus(8'h51, 50));
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t5_hold_vld", BUS_W'(issue_valid), BUS_W'(1));
      check("t5_hold_bus", issue_bus,           mk_bus(8'h51, 50));
      check("t5_hold_cnt", BUS_W'(count),       BUS_W'(1));
    end
    issue_ready = 1'b1;
    tick();
    check("t5_next_bus",   issue_bus,           mk_bus(8'h52, 51));
    check("t5_next_cnt",   BUS_W'(count),       BUS_W'(0));
    tick();
    check("t5_drained",    BUS_W'(issue_valid), BUS_W'(0));

    // 6: flush with 7 entries, a held issue and a concurrent dispatch
    issue_ready = 1'b0;
    drive(60, 8'h60, 1'b1);
    tick();
    for (int k = 0; k < 7; k++) begin
      drive(61 + k, 8'h70, 1'b0);
      tick();
    end
    check("t6_pre_cnt",    BUS_W'(count),       BUS_W'(7));
    check("t6_pre_vld",    BUS_W'(issue_valid), BUS_W'(1));
    drive(77, 8'h77, 1'b1);
    flush = 1'b1;
    tick(); flush = 1'b0; in_valid = 1'b0; issue_ready = 1'b1;
    check("t6_flush_cnt",  BUS_W'(count),       BUS_W'(0));
    check("t6_flush_vld",  BUS_W'(issue_valid), BUS_W'(0));
    tick();
    check("t6_dropped",    BUS_W'(issue_valid), BUS_W'(0));
    drive(80, 8'h80, 1'b1);
    tick(); in_valid = 1'b0;
    tick();
    check("t6_after_bus",  issue_bus,           mk_bus(8'h80, 80));

    // Asynchronous reset mid-operation
    drive(90, 8'h90, 1'b0);
    tick(); in_valid = 1'b0;
    check("ar_pre_cnt",    BUS_W'(count),       BUS_W'(1));
    #2 reset = 1'b1;
    #1;
    check("ar_count",      BUS_W'(count),       BUS_W'(0));
    check("ar_in_ready",   BUS_W'(in_ready),    BUS_W'(1));
    check("ar_issue_vld",  BUS_W'(issue_valid), BUS_W'(0));
    check("ar_issue_bus",  issue_bus,           BUS_W'(0));
    reset = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
